// File: rtl/xadc_emu_pkg.sv
// Shared constants, state encodings and helpers for the XADC DRP responder
// (xadc_drp_responder, xadc_emu_seq). Optional build macro: XADC_EMU_RAMP_EN.
package xadc_emu_pkg;

  localparam logic [6:0] ADDR_VAUX6  = 7'h16;
  localparam logic [6:0] ADDR_VAUX7  = 7'h17;
  localparam logic [6:0] ADDR_VAUX14 = 7'h1E;
  localparam logic [6:0] ADDR_VAUX15 = 7'h1F;
  localparam logic [6:0] CFG_BASE    = 7'h40;

  typedef enum logic {
    DRP_IDLE,
    DRP_WAIT
  } drp_state_t;

  typedef enum logic [1:0] {
    SEQ_WAIT_TICK,
    SEQ_CONVERT,
    SEQ_DONE
  } seq_state_t;

  // Round-robin slot -> DRP status address (VAUX6, 7, 14, 15).
  function automatic logic [6:0] chan_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    chan_addr = ADDR_VAUX6;
      2'd1:    chan_addr = ADDR_VAUX7;
      2'd2:    chan_addr = ADDR_VAUX14;
      default: chan_addr = ADDR_VAUX15;
    endcase
  endfunction

endpackage

// File: rtl/xadc_emu_seq.sv
// Conversion sequencer: free-running period counter, convert/done FSM, channel
// rotation and (with XADC_EMU_RAMP_EN defined) per-channel ramp sample sources.
module xadc_emu_seq
  import xadc_emu_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int CONV_CYCLES   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] aux6,
  input  logic [11:0] aux7,
  input  logic [11:0] aux14,
  input  logic [11:0] aux15,
  output logic        busy,
  output logic        eoc,
  output logic [4:0]  channel,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CMAX = CW'(CONV_CYCLES - 1);

  seq_state_t    state;
  logic [PW-1:0] period_cnt;
  logic [CW-1:0] conv_cnt;
  logic [1:0]    idx;
  logic [11:0]   sample;
  logic [11:0]   sample_src;

`ifdef XADC_EMU_RAMP_EN
  logic [11:0] ramp [4];
  assign sample_src = ramp[idx];
`else
  always_comb begin
    case (idx)
      2'd0:    sample_src = aux6;
      2'd1:    sample_src = aux7;
      2'd2:    sample_src = aux14;
      default: sample_src = aux15;
    endcase
  end
`endif

  // The status register is written on the clock edge that ends DONE, so a
  // read accepted during DONE still sees the previous sample.
  assign wr_en   = (state == SEQ_DONE);
  assign wr_addr = chan_addr(idx);
  assign wr_data = {sample, 4'h0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEQ_WAIT_TICK;
      period_cnt <= '0;
      conv_cnt   <= '0;
      idx        <= 2'd0;
      sample     <= 12'h000;
      busy       <= 1'b0;
      eoc        <= 1'b0;
      channel    <= 5'h00;
`ifdef XADC_EMU_RAMP_EN
      for (int i = 0; i < 4; i++) ramp[i] <= 12'h000;
`endif
    end else begin
      eoc        <= 1'b0;
      period_cnt <= (period_cnt == PMAX) ? '0 : period_cnt + 1'b1;
      case (state)
        SEQ_WAIT_TICK: begin
          if (period_cnt == PMAX) begin
            state    <= SEQ_CONVERT;
            busy     <= 1'b1;
            sample   <= sample_src;
            conv_cnt <= '0;
          end
        end
        SEQ_CONVERT: begin
          if (conv_cnt == CMAX) begin
            state   <= SEQ_DONE;
            busy    <= 1'b0;
            eoc     <= 1'b1;
            channel <= wr_addr[4:0];
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        SEQ_DONE: begin
          state <= SEQ_WAIT_TICK;
          idx   <= idx + 2'd1;
`ifdef XADC_EMU_RAMP_EN
          ramp[idx] <= ramp[idx] + 12'd1;
`endif
        end
        default: state <= SEQ_WAIT_TICK;
      endcase
    end
  end

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC wizard stand-in: DRP register file and DRP handshake FSM around the
// conversion sequencer. Build macro XADC_EMU_RAMP_EN selects ramp samples.
module xadc_drp_responder
  import xadc_emu_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int CONV_CYCLES   = 26,
  parameter int DRP_LATENCY   = 2
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  output logic        busy_out,
  input  logic [11:0] aux6_in,
  input  logic [11:0] aux7_in,
  input  logic [11:0] aux14_in,
  input  logic [11:0] aux15_in,
  output logic        drp_err
);

  localparam logic [3:0] LAT_LAST = 4'(DRP_LATENCY - 1);

  // DRP handshake: den_in is a one-cycle request, taken only in IDLE; the
  // matching drdy_out pulses DRP_LATENCY cycles later and do_out is zero
  // outside that pulse. A request seen in WAIT is dropped and flags drp_err.
  drp_state_t  drp_state;
  logic [3:0]  lat_cnt;
  logic [6:0]  req_addr;
  logic        req_we;
  logic [15:0] req_wdata;
  logic [15:0] req_rdata;
  logic [15:0] rd_val;
  logic [15:0] status [4];
  logic [15:0] cfg [3];

  logic        seq_wr_en;
  logic [6:0]  seq_wr_addr;
  logic [15:0] seq_wr_data;

  xadc_emu_seq #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CONV_CYCLES  (CONV_CYCLES)
  ) u_seq (
    .clk    (CLK100MHZ),
    .rst    (reset),
    .aux6   (aux6_in),
    .aux7   (aux7_in),
    .aux14  (aux14_in),
    .aux15  (aux15_in),
    .busy   (busy_out),
    .eoc    (eoc_out),
    .channel(channel_out),
    .wr_en  (seq_wr_en),
    .wr_addr(seq_wr_addr),
    .wr_data(seq_wr_data)
  );

  always_comb begin
    rd_val = 16'h0000;
    case (daddr_in)
      ADDR_VAUX6:         rd_val = status[0];
      ADDR_VAUX7:         rd_val = status[1];
      ADDR_VAUX14:        rd_val = status[2];
      ADDR_VAUX15:        rd_val = status[3];
      CFG_BASE:           rd_val = cfg[0];
      CFG_BASE + 7'd1:    rd_val = cfg[1];
      CFG_BASE + 7'd2:    rd_val = cfg[2];
      default:            rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) status[i] <= 16'h0000;
    end else if (seq_wr_en) begin
      case (seq_wr_addr)
        ADDR_VAUX6:  status[0] <= seq_wr_data;
        ADDR_VAUX7:  status[1] <= seq_wr_data;
        ADDR_VAUX14: status[2] <= seq_wr_data;
        default:     status[3] <= seq_wr_data;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      drp_state <= DRP_IDLE;
      lat_cnt   <= 4'd0;
      req_addr  <= 7'h00;
      req_we    <= 1'b0;
      req_wdata <= 16'h0000;
      req_rdata <= 16'h0000;
      drdy_out  <= 1'b0;
      do_out    <= 16'h0000;
      drp_err   <= 1'b0;
      for (int i = 0; i < 3; i++) cfg[i] <= 16'h0000;
    end else begin
      case (drp_state)
        DRP_IDLE: begin
          if (den_in) begin
            drp_state <= DRP_WAIT;
            req_addr  <= daddr_in;
            req_we    <= dwe_in;
            req_wdata <= di_in;
            req_rdata <= rd_val;
            lat_cnt   <= 4'd1;
            if (DRP_LATENCY == 1) begin
              drdy_out <= 1'b1;
              do_out   <= dwe_in ? 16'h0000 : rd_val;
            end
          end
        end
        DRP_WAIT: begin
          if (den_in) drp_err <= 1'b1;
          if (drdy_out) begin
            drp_state <= DRP_IDLE;
            drdy_out  <= 1'b0;
            do_out    <= 16'h0000;
            if (req_we) begin
              case (req_addr)
                CFG_BASE:        cfg[0] <= req_wdata;
                CFG_BASE + 7'd1: cfg[1] <= req_wdata;
                CFG_BASE + 7'd2: cfg[2] <= req_wdata;
                default: ;
              endcase
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
            if (lat_cnt == LAT_LAST) begin
              drdy_out <= 1'b1;
              do_out   <= req_we ? 16'h0000 : req_rdata;
            end
          end
        end
        default: drp_state <= DRP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder; define XADC_EMU_RAMP_EN to
// exercise the ramp sample build instead of the aux-input build.
module tb_xadc_drp_responder;

  localparam int SP   = 40;
  localparam int CONV = 26;
  localparam int LAT  = 2;

  logic        clk;
  logic        reset;
  logic        den, dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] do_out;
  logic        drdy_out, eoc_out, busy_out, drp_err;
  logic [4:0]  channel_out;
  logic [11:0] aux6, aux7, aux14, aux15;

  int total = 0;
  int bad   = 0;

  xadc_drp_responder #(
    .SAMPLE_PERIOD(SP),
    .CONV_CYCLES  (CONV),
    .DRP_LATENCY  (LAT)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .den_in     (den),
    .dwe_in     (dwe),
    .daddr_in   (daddr),
    .di_in      (di),
    .do_out     (do_out),
    .drdy_out   (drdy_out),
    .eoc_out    (eoc_out),
    .channel_out(channel_out),
    .busy_out   (busy_out),
    .aux6_in    (aux6),
    .aux7_in    (aux7),
    .aux14_in   (aux14),
    .aux15_in   (aux15),
    .drp_err    (drp_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // n = clock edges since reset release. Conversion k starts on edge SP*(k+1),
  // eoc is high after edge SP*(k+1)+CONV, the status register takes the new
  // sample on the following edge.
  int          n;
  logic [15:0] stat_m [4];
  logic [15:0] cfg_m [3];
  logic [11:0] ramp_m [4];
  logic [11:0] pend;
  int          pend_ch;

  function automatic logic [11:0] aux_of(int ch);
    case (ch)
      0: return aux6;
      1: return aux7;
      2: return aux14;
      default: return aux15;
    endcase
  endfunction

  function automatic logic [6:0] addr_of(int ch);
    case (ch % 4)
      0: return 7'h16;
      1: return 7'h17;
      2: return 7'h1E;
      default: return 7'h1F;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n <= 0;
      pend <= 12'h0;
      pend_ch <= 0;
      for (int i = 0; i < 4; i++) begin
        stat_m[i] <= 16'h0;
        ramp_m[i] <= 12'h0;
      end
    end else begin
      n <= n + 1;
      if ((n + 1) >= SP && (n + 1) % SP == 0) begin
        pend_ch <= ((n + 1) / SP - 1) % 4;
`ifdef XADC_EMU_RAMP_EN
        pend <= ramp_m[((n + 1) / SP - 1) % 4];
        ramp_m[((n + 1) / SP - 1) % 4] <= ramp_m[((n + 1) / SP - 1) % 4] + 12'd1;
`else
        pend <= aux_of(((n + 1) / SP - 1) % 4);
`endif
      end
      if ((n + 1) >= SP && (n + 1) % SP == CONV + 1)
        stat_m[pend_ch] <= {pend, 4'h0};
    end
  end

  function automatic logic exp_busy(int k);
    return (k >= SP) && (k % SP < CONV);
  endfunction

  function automatic logic exp_eoc(int k);
    return (k >= SP) && (k % SP == CONV);
  endfunction

  function automatic logic [4:0] exp_chan(int k);
    int c;
    logic [6:0] a;
    c = (k >= SP + CONV) ? (k - SP - CONV) / SP + 1 : 0;
    a = addr_of(c - 1);
    return (c == 0) ? 5'h00 : a[4:0];
  endfunction

  function automatic logic [15:0] model_read(logic [6:0] a);
    case (a)
      7'h16: return stat_m[0];
      7'h17: return stat_m[1];
      7'h1E: return stat_m[2];
      7'h1F: return stat_m[3];
      7'h40: return cfg_m[0];
      7'h41: return cfg_m[1];
      7'h42: return cfg_m[2];
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    den = 1'b0;
    dwe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cfg_m[i] = 16'h0;
  endtask

  task automatic wait_n(input int target);
    for (int i = 0; i < 20000 && n < target; i++) @(negedge clk);
    if (n != target) begin
      total++;
      bad++;
      $display("FAIL wait_n: reached n=%0d, required %0d", n, target);
    end
  endtask

  // One DRP transaction starting at a negedge; reports what the DUT did.
  task automatic drp_xfer(input logic [6:0] a, input logic w, input logic [15:0] d,
                          output logic [15:0] exp_v, output int pos, output int pulses,
                          output logic [15:0] got, output int stray);
    exp_v = w ? 16'h0000 : model_read(a);
    den = 1'b1;
    dwe = w;
    daddr = a;
    di = d;
    pos = -1;
    pulses = 0;
    got = 16'h0;
    stray = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        den = 1'b0;
        dwe = 1'b0;
      end
      if (drdy_out === 1'b1) begin
        pulses++;
        if (pos < 0) begin
          pos = i;
          got = do_out;
        end
      end else if (do_out !== 16'h0000) begin
        stray++;
      end
    end
    if (w && a >= 7'h40 && a <= 7'h42) cfg_m[a - 7'h40] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({do_out, drdy_out, eoc_out, channel_out, busy_out, drp_err} !== 25'h0) begin
      bad++;
      $display("FAIL reset_outputs: do=%h drdy=%b eoc=%b ch=%h busy=%b err=%b, required all 0",
               do_out, drdy_out, eoc_out, channel_out, busy_out, drp_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cfg_m[i] = 16'h0;
  endtask

  task automatic test_first_conv();
    logic [15:0] e, g;
    int pos, pulses, stray, eocs;
    aux6 = 12'hABC;
    do_reset();
    eocs = 0;
    while (n <= SP + CONV + 1) begin
      total++;
      if (busy_out !== exp_busy(n) || eoc_out !== exp_eoc(n) || channel_out !== exp_chan(n)) begin
        bad++;
        $display("FAIL first_conv n=%0d: busy=%b eoc=%b ch=%h, required %b %b %h",
                 n, busy_out, eoc_out, channel_out, exp_busy(n), exp_eoc(n), exp_chan(n));
      end
      if (eoc_out === 1'b1) eocs++;
      @(negedge clk);
    end
    total++;
    if (eocs !== 1 || channel_out !== 5'h16) begin
      bad++;
      $display("FAIL first_eoc: pulses=%0d ch=%h, required 1 and 16", eocs, channel_out);
    end
    drp_xfer(7'h16, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (pos !== LAT || pulses !== 1 || g !== 16'hABC0 || stray !== 0) begin
      bad++;
      $display("FAIL read_vaux6: pos=%0d pulses=%0d do=%h stray=%0d, required %0d 1 ABC0 0",
               pos, pulses, g, stray, LAT);
    end
  endtask

  task automatic test_sequencer();
    logic [15:0] e, g;
    int pos, pulses, stray;
    do_reset();
    for (int c = 0; c < 5 * SP + 4; c++) begin
      aux6 = 12'($urandom_range(0, 4095));
      aux7 = 12'($urandom_range(0, 4095));
      aux14 = 12'($urandom_range(0, 4095));
      aux15 = 12'($urandom_range(0, 4095));
      @(negedge clk);
      total++;
      if (busy_out !== exp_busy(n) || eoc_out !== exp_eoc(n) || channel_out !== exp_chan(n)) begin
        bad++;
        $display("FAIL seq n=%0d: busy=%b eoc=%b ch=%h, required %b %b %h",
                 n, busy_out, eoc_out, channel_out, exp_busy(n), exp_eoc(n), exp_chan(n));
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      drp_xfer(addr_of(ch), 1'b0, 16'h0, e, pos, pulses, g, stray);
      total++;
      if (pos !== LAT || pulses !== 1 || g !== e || stray !== 0) begin
        bad++;
        $display("FAIL seq_status %h: pos=%0d pulses=%0d do=%h, required %0d 1 %h",
                 addr_of(ch), pos, pulses, g, LAT, e);
      end
    end
  endtask

  task automatic test_cfg();
    logic [15:0] e, g, d;
    logic [6:0] a;
    logic w;
    int pos, pulses, stray;
    logic [6:0] addrs [8];
    addrs = '{7'h16, 7'h17, 7'h1E, 7'h1F, 7'h40, 7'h41, 7'h42, 7'h30};
    drp_xfer(7'h41, 1'b1, 16'h1234, e, pos, pulses, g, stray);
    total++;
    if (pos !== LAT || pulses !== 1 || g !== 16'h0000 || stray !== 0) begin
      bad++;
      $display("FAIL write_41: pos=%0d pulses=%0d do=%h, required %0d 1 0000", pos, pulses, g, LAT);
    end
    drp_xfer(7'h41, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== 16'h1234 || pos !== LAT) begin
      bad++;
      $display("FAIL read_41: do=%h pos=%0d, required 1234 %0d", g, pos, LAT);
    end
    drp_xfer(7'h16, 1'b1, 16'hFFFF, e, pos, pulses, g, stray);
    drp_xfer(7'h16, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== e || g === 16'hFFFF) begin
      bad++;
      $display("FAIL status_write_ignored: do=%h, required %h", g, e);
    end
    drp_xfer(7'h30, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== 16'h0000 || pulses !== 1) begin
      bad++;
      $display("FAIL read_unmapped: do=%h pulses=%0d, required 0000 1", g, pulses);
    end
    for (int t = 0; t < 24; t++) begin
      a = addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = 7'($urandom_range(0, 127));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom_range(0, 65535));
      drp_xfer(a, w, d, e, pos, pulses, g, stray);
      total++;
      if (pos !== LAT || pulses !== 1 || g !== e || stray !== 0) begin
        bad++;
        $display("FAIL rand_drp a=%h we=%b: pos=%0d pulses=%0d do=%h stray=%0d, required %0d 1 %h 0",
                 a, w, pos, pulses, g, stray, LAT, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, got;
    int first, second, pulses;
    d = 16'($urandom_range(0, 65535));
    first = -1;
    second = -1;
    pulses = 0;
    got = 16'h0;
    den = 1'b1; dwe = 1'b1; daddr = 7'h42; di = d;
    for (int i = 1; i <= 2 * LAT + 3; i++) begin
      @(negedge clk);
      if (drdy_out === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else begin
          second = i;
          got = do_out;
        end
      end
      if (i == LAT + 1) begin
        den = 1'b1; dwe = 1'b0; daddr = 7'h42;
      end else begin
        den = 1'b0; dwe = 1'b0;
      end
    end
    cfg_m[2] = d;
    total++;
    if (pulses !== 2 || first !== LAT || second !== 2 * LAT + 1 || got !== d || drp_err !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: pulses=%0d at %0d,%0d do=%h err=%b, required 2 at %0d,%0d %h 0",
               pulses, first, second, got, drp_err, LAT, 2 * LAT + 1, d);
    end
  endtask

  task automatic test_drp_err();
    logic [15:0] e, g;
    int pos, pulses, stray;
    total++;
    if (drp_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_before: err=%b, required 0", drp_err);
    end
    pulses = 0;
    den = 1'b1; dwe = 1'b0; daddr = 7'h41;
    @(negedge clk);
    dwe = 1'b1; daddr = 7'h40; di = 16'hFFFF;
    for (int i = 2; i <= LAT + 5; i++) begin
      @(negedge clk);
      den = 1'b0; dwe = 1'b0;
      if (drdy_out === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1 || drp_err !== 1'b1) begin
      bad++;
      $display("FAIL overlap: drdy pulses=%0d err=%b, required 1 1", pulses, drp_err);
    end
    drp_xfer(7'h40, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== e || drp_err !== 1'b1) begin
      bad++;
      $display("FAIL overlap_write_dropped: do=%h err=%b, required %h 1", g, drp_err, e);
    end
    do_reset();
    total++;
    if (drp_err !== 1'b0) begin
      bad++;
      $display("FAIL err_after_reset: err=%b, required 0", drp_err);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] e, g;
    int pos, pulses, stray;
    aux7 = 12'h000;
    do_reset();
    aux7 = 12'h800;
    wait_n(2 * SP + CONV);
    total++;
    if (eoc_out !== 1'b1 || channel_out !== 5'h17) begin
      bad++;
      $display("FAIL done_vaux7: eoc=%b ch=%h, required 1 17", eoc_out, channel_out);
    end
    drp_xfer(7'h17, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== 16'h0000 || e !== 16'h0000) begin
      bad++;
      $display("FAIL read_in_done: do=%h model=%h, required 0000", g, e);
    end
    drp_xfer(7'h17, 1'b0, 16'h0, e, pos, pulses, g, stray);
    total++;
    if (g !== 16'h8000 || e !== 16'h8000) begin
      bad++;
      $display("FAIL read_after_done: do=%h model=%h, required 8000", g, e);
    end
  endtask

  task automatic test_reset_mid();
    int late;
    late = 0;
    den = 1'b1; dwe = 1'b0; daddr = 7'h40;
    @(negedge clk);
    den = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 3; i < 3; i++) cfg_m[i] = 16'h0;
    for (int i = 0; i < 3; i++) cfg_m[i] = 16'h0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      if (drdy_out !== 1'b0 || do_out !== 16'h0 || eoc_out !== 1'b0) late++;
    end
    total++;
    if (late !== 0) begin
      bad++;
      $display("FAIL reset_in_wait: %0d cycles with drdy/do/eoc active, required 0", late);
    end
    wait_n(SP + 5);
    total++;
    if (busy_out !== 1'b1) begin
      bad++;
      $display("FAIL busy_before_reset: busy=%b, required 1", busy_out);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({do_out, drdy_out, eoc_out, channel_out, busy_out, drp_err} !== 25'h0) begin
      bad++;
      $display("FAIL reset_in_convert: do=%h drdy=%b eoc=%b ch=%h busy=%b err=%b, required all 0",
               do_out, drdy_out, eoc_out, channel_out, busy_out, drp_err);
    end
    @(negedge clk);
    reset = 1'b0;
    late = 0;
    while (n < SP + CONV) begin
      @(negedge clk);
      if (eoc_out !== exp_eoc(n) || busy_out !== exp_busy(n)) late++;
    end
    total++;
    if (late !== 0 || eoc_out !== 1'b1 || channel_out !== 5'h16) begin
      bad++;
      $display("FAIL first_eoc_after_reset: bad_cycles=%0d eoc=%b ch=%h, required 0 1 16",
               late, eoc_out, channel_out);
    end
  endtask

`ifdef XADC_EMU_RAMP_EN
  task automatic test_ramp();
    logic [15:0] e, g;
    int pos, pulses, stray, busy_cnt;
    logic [11:0] m12;
    do_reset();
    for (int m = 0; m < 6; m++) begin
      wait_n(SP * (4 * m + 1) - 1);
      busy_cnt = 0;
      for (int i = 0; i < CONV + 3; i++) begin
        @(negedge clk);
        if (busy_out === 1'b1) busy_cnt++;
      end
      m12 = 12'(m);
      drp_xfer(7'h16, 1'b0, 16'h0, e, pos, pulses, g, stray);
      total++;
      if (g !== {m12, 4'h0} || busy_cnt !== CONV) begin
        bad++;
        $display("FAIL ramp conv %0d: do=%h busy_cycles=%0d, required %h %0d",
                 m, g, busy_cnt, {m12, 4'h0}, CONV);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    den = 1'b0; dwe = 1'b0; daddr = 7'h0; di = 16'h0;
    aux6 = 12'h0; aux7 = 12'h0; aux14 = 12'h0; aux15 = 12'h0;
    for (int i = 0; i < 3; i++) cfg_m[i] = 16'h0;
    test_reset();
`ifdef XADC_EMU_RAMP_EN
    test_ramp();
`else
    test_first_conv();
    test_sequencer();
`endif
    test_cfg();
    test_back_to_back();
    test_drp_err();
`ifndef XADC_EMU_RAMP_EN
    test_simultaneous();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
